// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU boot path.
//   ld_state_e   : instruction-memory loader FSM states
//   LD_ERR_*     : loader err_code values
//   INSTR_W      : instruction word width
package cpu_pkg;

    localparam int unsigned INSTR_W = 16;

    localparam logic [1:0] LD_ERR_NONE = 2'd0;
    localparam logic [1:0] LD_ERR_LEN  = 2'd1;
    localparam logic [1:0] LD_ERR_CSUM = 2'd2;

    typedef enum logic [2:0] {
        StCntHi,
        StCntLo,
        StWHi,
        StWLo,
        StCsum,
        StDone,
        StErr
    } ld_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready channel feeding the instruction-memory loader.
//   s_valid : byte valid (producer -> loader)
//   s_data  : byte value (producer -> loader)
//   s_ready : loader accepts a byte (loader -> producer)
// master = byte producer, slave = loader.
interface imem_loader_if;

    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );

endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer. Receives a byte stream
// (count hi/lo, N big-endian words, XOR checksum), writes each word to
// consecutive instruction-memory addresses and keeps the CPU in reset until
// a complete image with a good checksum has been loaded.
//   clk, reset_n : clock, asynchronous active-low reset
//   s_if         : byte stream (slave side)
//   restart      : pulse to start a new load from DONE or ERR
//   mem_we/addr/wdata : registered instruction-memory write port
//   cpu_hold     : CPU reset, high until a clean load finishes
//   done         : load complete with good checksum
//   err_code     : LD_ERR_NONE / LD_ERR_LEN / LD_ERR_CSUM
module imem_loader
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    imem_loader_if.slave        s_if,
    input  logic                restart,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [INSTR_W-1:0]  mem_wdata,
    output logic                cpu_hold,
    output logic                done,
    output logic [1:0]          err_code
);

    // Largest legal word count is the full memory capacity.
    localparam logic [16:0] MaxWords = 17'(1) << ADDR_W;

    ld_state_e            state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [7:0]           acc_q, acc_d;
    logic [7:0]           hi_q, hi_d;
    logic                 we_q, we_d;
    logic [INSTR_W-1:0]   wdata_q, wdata_d;
    logic [1:0]           err_q, err_d;

    logic        accept;
    logic [15:0] count_in;

    assign s_if.s_ready = (state_q != StDone) && (state_q != StErr);
    assign accept       = s_if.s_valid && s_if.s_ready;
    assign count_in     = {hi_q, s_if.s_data};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        we_d    = 1'b0;
        wdata_d = wdata_q;
        err_d   = err_q;

        // The address shown with a write stays put for that cycle, then advances.
        if (we_q) begin
            addr_d = addr_q + ADDR_W'(1);
        end

        if (accept && (state_q != StCsum)) begin
            acc_d = acc_q ^ s_if.s_data;
        end

        case (state_q)
            StCntHi: begin
                if (accept) begin
                    hi_d    = s_if.s_data;
                    state_d = StCntLo;
                end
            end
            StCntLo: begin
                if (accept) begin
                    if (count_in == 16'd0) begin
                        state_d = StCsum;
                    end else if ({1'b0, count_in} > MaxWords) begin
                        state_d = StErr;
                        err_d   = LD_ERR_LEN;
                    end else begin
                        cnt_d   = count_in;
                        state_d = StWHi;
                    end
                end
            end
            StWHi: begin
                if (accept) begin
                    hi_d    = s_if.s_data;
                    state_d = StWLo;
                end
            end
            StWLo: begin
                if (accept) begin
                    we_d    = 1'b1;
                    wdata_d = {hi_q, s_if.s_data};
                    cnt_d   = cnt_q - 16'd1;
                    state_d = (cnt_q == 16'd1) ? StCsum : StWHi;
                end
            end
            StCsum: begin
                if (accept) begin
                    if (s_if.s_data == acc_q) begin
                        state_d = StDone;
                    end else begin
                        state_d = StErr;
                        err_d   = LD_ERR_CSUM;
                    end
                end
            end
            StDone, StErr: begin
                if (restart) begin
                    state_d = StCntHi;
                    err_d   = LD_ERR_NONE;
                    addr_d  = '0;
                    acc_d   = '0;
                end
            end
            default: begin
                state_d = StCntHi;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StCntHi;
            cnt_q   <= '0;
            addr_q  <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            err_q   <= LD_ERR_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign done      = (state_q == StDone);
    assign cpu_hold  = (state_q != StDone);
    assign err_code  = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized bench for imem_loader: builds byte images, drives
// them with optional valid gaps, and compares the observed memory writes and
// final status against a stream-level reference model.
module tb_imem_loader;

    localparam int AW = 8;

    logic            clk;
    logic            reset_n;
    logic            restart;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [15:0]     mem_wdata;
    logic            cpu_hold;
    logic            done;
    logic [1:0]      err_code;

    imem_loader_if bus ();

    imem_loader #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_if      (bus),
        .restart   (restart),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err_code  (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] stim[$];
    int         exp_addr[$];
    int         exp_data[$];
    int         obs_addr[$];
    int         obs_data[$];
    logic       e_done;
    int         e_err;
    int         e_final_addr;

    // Record every write the DUT presents, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we) begin
            obs_addr.push_back(int'(mem_addr));
            obs_data.push_back(int'(mem_wdata));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: parse the stream by its format rules.
    task automatic model();
        int n;
        logic [7:0] x;
        exp_addr.delete();
        exp_data.delete();
        n = int'({stim[0], stim[1]});
        x = stim[0] ^ stim[1];
        if (n > (1 << AW)) begin
            e_done       = 1'b0;
            e_err        = 1;
            e_final_addr = 0;
            return;
        end
        for (int k = 0; k < n; k++) begin
            exp_addr.push_back(k % (1 << AW));
            exp_data.push_back(int'({stim[2 + 2 * k], stim[3 + 2 * k]}));
            x = x ^ stim[2 + 2 * k] ^ stim[3 + 2 * k];
        end
        e_done       = (stim[2 + 2 * n] == x);
        e_err        = e_done ? 0 : 2;
        e_final_addr = n % (1 << AW);
    endtask

    task automatic make_image(input int n, input bit bad);
        logic [7:0] x;
        logic [15:0] w;
        stim.delete();
        w = 16'(n);
        stim.push_back(w[15:8]);
        stim.push_back(w[7:0]);
        for (int k = 0; k < 2 * n; k++) stim.push_back(8'($urandom));
        x = 8'h00;
        foreach (stim[i]) x = x ^ stim[i];
        stim.push_back(bad ? (x ^ 8'h5a) : x);
    endtask

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        int tries;
        int g;
        g = 0;
        while (gap_pct > 0 && g < 8 && $urandom_range(99) < gap_pct) begin
            bus.s_valid = 1'b0;
            @(negedge clk);
            g++;
        end
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        tries = 0;
        while (!bus.s_ready && tries < 50) begin
            @(negedge clk);
            tries++;
        end
        if (tries >= 50) chk("ready_timeout", 32'(bus.s_ready), 32'd1);
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic run_image(input string tag, input int gap_pct);
        int m;
        model();
        obs_addr.delete();
        obs_data.delete();
        foreach (stim[i]) send_byte(stim[i], gap_pct);
        // Status must be visible in the cycle right after the final byte.
        chk({tag, "_done"}, 32'(done), 32'(e_done));
        chk({tag, "_hold"}, 32'(cpu_hold), 32'(!e_done));
        chk({tag, "_err"}, 32'(err_code), 32'(e_err));
        chk({tag, "_ready"}, 32'(bus.s_ready), 32'd0);
        repeat (3) @(negedge clk);
        chk({tag, "_nwrites"}, 32'(obs_addr.size()), 32'(exp_addr.size()));
        m = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
        for (int k = 0; k < m; k++) begin
            chk({tag, "_waddr"}, 32'(obs_addr[k]), 32'(exp_addr[k]));
            chk({tag, "_wdata"}, 32'(obs_data[k]), 32'(exp_data[k]));
        end
        chk({tag, "_final_addr"}, 32'(mem_addr), 32'(e_final_addr));
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("restart_ready", 32'(bus.s_ready), 32'd1);
        chk("restart_hold", 32'(cpu_hold), 32'd1);
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_err", 32'(err_code), 32'd0);
        chk("restart_addr", 32'(mem_addr), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"}, 32'(bus.s_ready), 32'd1);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err_code), 32'd0);
    endtask

    initial begin
        reset_n     = 1'b0;
        restart     = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Two-word image, back-to-back.
        stim = '{8'h00, 8'h02, 8'h11, 8'h23, 8'h23, 8'h45, 8'h56};
        run_image("two_words", 0);
        pulse_restart();

        // Same image with valid gaps.
        stim = '{8'h00, 8'h02, 8'h11, 8'h23, 8'h23, 8'h45, 8'h56};
        run_image("two_words_gaps", 50);
        pulse_restart();

        // Empty image.
        stim = '{8'h00, 8'h00, 8'h00};
        run_image("empty", 0);
        pulse_restart();

        // Count one beyond capacity.
        stim = '{8'h01, 8'h01};
        run_image("len_err", 0);
        pulse_restart();

        // Bad checksum after one word.
        stim = '{8'h00, 8'h01, 8'h80, 8'h01, 8'h00};
        run_image("csum_err", 0);
        pulse_restart();

        // Random images, good and bad, with gaps.
        for (int t = 0; t < 4; t++) begin
            make_image(int'($urandom_range(20, 1)), (t == 2));
            run_image("random", 30);
            pulse_restart();
        end

        // Exactly full capacity: address wraps after the last write.
        make_image(1 << AW, 1'b0);
        run_image("full", 10);
        pulse_restart();

        // Reset in the middle of a load.
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h11, 0);
        reset_n = 1'b0;
        #1;
        check_reset_values("midload_reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Clean load, then restart and overwrite from address 0.
        make_image(5, 1'b0);
        run_image("after_reset", 0);
        pulse_restart();
        make_image(3, 1'b0);
        run_image("reload", 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory writer for the 16-bit pipelined CPU. Accepts a byte stream over a valid/ready handshake, assembles big-endian 16-bit instruction words and writes them sequentially into the CPU instruction memory through its write port. It verifies a trailing XOR checksum and holds the CPU in reset until a complete, error-free image is loaded. The CPU fetch stage is the reader of what this block writes.

## Interface
- `ADDR_W`, 8: instruction memory address width; capacity is 2^ADDR_W words.
- `clk`  in  1  single system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  input byte valid.
- `s_data`  in  8  input byte.
- `s_ready`  out  1  block accepts a byte; a transfer occurs when `s_valid && s_ready` at a rising edge.
- `restart`  in  1  single-cycle pulse that begins a new load from DONE or ERR.
- `mem_we`  out  1  instruction memory write enable, one-cycle pulse per word.
- `mem_addr`  out  ADDR_W  write address.
- `mem_wdata`  out  16  write data.
- `cpu_hold`  out  1  drives CPU reset; high until a load completes cleanly.
- `done`  out  1  load complete, checksum good.
- `err_code`  out  2  0 none, 1 length error, 2 checksum error.

## Operation
- Stream format: CNT_HI, CNT_LO (16-bit word count N, big-endian), then N words as (HI, LO) byte pairs, then one checksum byte equal to the XOR of every preceding byte, count bytes included.
- States: CNT_HI -> CNT_LO -> W_HI <-> W_LO -> CSUM -> DONE or ERR.
- Each state advances only on an accepted byte. A running XOR accumulates every accepted byte except the checksum byte.
- After CNT_LO:
  - N == 0: go to CSUM.
  - N > 2^ADDR_W: go to ERR with `err_code`=1.
  - Otherwise: go to W_HI.
- W_LO accept: register the word and pulse `mem_we`. Increment the address. Decrement the remaining count; when it reaches 0, go to CSUM.
- CSUM accept: match goes to DONE; mismatch goes to ERR with `err_code`=2. Words already written stay in memory.
- `s_ready` is 1 in CNT_HI through CSUM and 0 in DONE and ERR.
- `restart` in DONE or ERR: go to CNT_HI. This clears `done`, `err_code`, the address and the XOR accumulator, and sets `cpu_hold`=1. `restart` in any other state is ignored.

## Timing
- Reset values: state CNT_HI, `s_ready`=1, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_hold`=1, `done`=0, `err_code`=0, accumulator 0.
- Reset mid-load aborts immediately to the reset values. Memory contents are not cleared.
- One byte can be accepted per cycle. `s_valid` gaps only stall the FSM and have no other effect.
- `mem_we`, `mem_addr` and `mem_wdata` are registered:
  - They are valid in the cycle after the W_LO byte is accepted.
  - `mem_addr` holds the address of that write. It advances after the write, so the k-th word lands at address k-1.
- `done` rises, and `cpu_hold` falls, in the cycle after the checksum byte is accepted. The last `mem_we` always precedes that cycle.
- `err_code` is set in the cycle after the offending byte is accepted. `s_ready` drops in that same cycle.
- With N = 2^ADDR_W, the address wraps to 0 after the final write, and no further write occurs.

## Structure
- Shared package `cpu_pkg`: loader state enum, `err_code` constants (`LD_ERR_NONE`, `LD_ERR_LEN`, `LD_ERR_CSUM`), and the instruction width constant (16).
- Single module with no sub-modules: one FSM, a 16-bit down-counter, an ADDR_W address counter, an 8-bit XOR accumulator and a high-byte holding register.

## Test plan
- Send 00 02 11 23 23 45 56 back-to-back -> `mem_we` pulses write addr0=0x1123 and addr1=0x2345; then `done`=1, `cpu_hold`=0, `err_code`=0.
- Send the same stream with random `s_valid` gaps -> identical writes and final state; no extra `mem_we` pulses.
- Send 00 00 00 -> no `mem_we`; `done`=1, `cpu_hold`=0.
- With ADDR_W=8, send 01 01 -> `err_code`=1 one cycle after the second byte; `s_ready`=0; `cpu_hold`=1; no writes.
- Send 00 01 80 01 00 (correct checksum is 0x80) -> addr0 is written with 0x8001; then `err_code`=2, `cpu_hold`=1, `done`=0.
- Assert `reset_n`=0 after 3 bytes of a load -> all outputs return to reset values. Then pulse `restart` from DONE after a clean load and send a second full image -> new words overwrite from addr0 and `done` reasserts.
